fp32_accumulator: RTL



---
 rtl/heepstor_fp32_pkg.sv | 18 +
 rtl/Find_First_Set_Bit.sv | 21 ++
 rtl/fp32_accumulator.sv | 126 ++++++++++++
 3 files changed

// File: rtl/heepstor_fp32_pkg.sv
// heepstor_fp32_pkg: shared FP32 field widths, constants, types and accumulator states
package heepstor_fp32_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS = 127;
  localparam logic [31:0] FP32_MAX_FIN = 32'h7F7FFFFF;
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_ADDN  = 2'd2,
    ST_OUT   = 2'd3
  } acc_state_e;
endpackage

// File: rtl/Find_First_Set_Bit.sv
// Find_First_Set_Bit: index of the most significant set bit, plus a found flag
module Find_First_Set_Bit #(
  parameter int WIDTH = 25,
  localparam int IW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [IW-1:0]    index_o,
  output logic             found_o
);
  // scan upward so the highest set bit is the last one written
  always_comb begin
    index_o = '0;
    found_o = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_i[i]) begin
        index_o = IW'(i);
        found_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fp32_accumulator.sv
// fp32_accumulator: sequential simplified-FP32 dot-product accumulator with valid/ready output
module fp32_accumulator
  import heepstor_fp32_pkg::*;
#(
  parameter bit SAT_ENABLE = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_data_i,
  input  logic        in_last_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o
);
  acc_state_e  state_q, state_d;
  fp32_t       acc_q, acc_d, op_q, op_d, lg_q, lg_d;
  logic        last_q, last_d, sub_q, sub_d, vld_q, vld_d;
  logic [23:0] sm_q, sm_d;
  fp32_t       a, b, lg;
  logic        az, bz, a_big;
  logic [23:0] ma, mb, sm_raw, lg_m;
  logic [7:0]  ediff;
  logic [24:0] sum, norm;
  logic [4:0]  lo_idx, lz;
  logic        found, flush, ovf;
  logic [9:0]  exp_n;
  logic [22:0] frac;
  fp32_t       res;
  assign a      = acc_q;
  assign b      = op_q;
  assign az     = a.exp == '0;
  assign bz     = b.exp == '0;
  assign ma     = {1'b1, a.man};
  assign mb     = {1'b1, b.man};
  assign a_big  = (a.exp > b.exp) || (a.exp == b.exp && ma >= mb);
  // a zero operand lets the other through untouched; two zeros collapse to +0
  assign lg     = bz ? (az ? '0 : a) : az ? b : a_big ? a : b;
  assign sm_raw = a_big ? mb : ma;
  assign ediff  = a_big ? a.exp - b.exp : b.exp - a.exp;
  assign lg_m   = {lg_q.exp != '0, lg_q.man};
  assign sum    = sub_q ? {1'b0, lg_m} - {1'b0, sm_q} : {1'b0, lg_m} + {1'b0, sm_q};
  Find_First_Set_Bit #(.WIDTH(25)) u_ffs (
    .in_i   (sum),
    .index_o(lo_idx),
    .found_o(found)
  );
  // subtraction results stay below 2^24, so the leading one sits at bit 23 or lower
  assign lz     = 5'd23 - lo_idx;
  assign norm   = sum << lz;
  assign exp_n  = sub_q ? {2'b0, lg_q.exp} - {5'b0, lz} : {2'b0, lg_q.exp} + {9'b0, sum[24]};
  assign frac   = sub_q ? norm[22:0] : sum[24] ? sum[23:1] : sum[22:0];
  assign flush  = !found || exp_n[9] || exp_n == '0;
  assign ovf    = !flush && exp_n >= 10'd255;
  assign res    = flush ? '0 : (ovf && SAT_ENABLE) ? {lg_q.sign, FP32_MAX_FIN[30:0]}
                                                   : {lg_q.sign, exp_n[7:0], frac};
  // FSM next state: clear wins everywhere, then accept -> align -> add -> optional output
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    last_d  = last_q;
    lg_d    = lg_q;
    sm_d    = sm_q;
    sub_d   = sub_q;
    vld_d   = vld_q;
    if (clear_i) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      vld_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (in_valid_i) begin
          op_d    = in_data_i;
          last_d  = in_last_i;
          state_d = ST_ALIGN;
        end
        ST_ALIGN: begin
          lg_d    = lg;
          sm_d    = (az || bz || ediff >= 8'd25) ? '0 : sm_raw >> ediff;
          sub_d   = !az && !bz && (a.sign != b.sign);
          state_d = ST_ADDN;
        end
        ST_ADDN: begin
          acc_d   = res;
          state_d = last_q ? ST_OUT : ST_IDLE;
        end
        default: begin
          vld_d = 1'b1;
          if (vld_q && out_ready_i) begin
            acc_d   = '0;
            vld_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end
      endcase
    end
  end
  // state registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      op_q    <= '0;
      last_q  <= 1'b0;
      lg_q    <= '0;
      sm_q    <= '0;
      sub_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      last_q  <= last_d;
      lg_q    <= lg_d;
      sm_q    <= sm_d;
      sub_q   <= sub_d;
      vld_q   <= vld_d;
    end
  end
  assign in_ready_o  = state_q == ST_IDLE;
  assign out_valid_o = vld_q;
  assign out_data_o  = acc_q;
endmodule
